// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared constants, word/index types and FSM states for the dense bias stage
package dense_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int NUM_NEURONS = 10;
    localparam int ADR_SIZE    = $clog2(NUM_NEURONS);

    typedef logic signed [WORD_SIZE-1:0] word_t;
    typedef logic [ADR_SIZE-1:0]         idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_NEURONS - 1);

endpackage

// File: rtl/dense_bias_adder_if.sv
// rtl/dense_bias_adder_if.sv - accumulator-in and result-out stream handshakes of the bias stage
interface dense_bias_adder_if;
    import dense_pkg::*;

    logic  acc_valid;
    logic  acc_ready;
    word_t acc_data;

    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    idx_t  out_idx;
    logic  out_last;

    // Environment side: feeds accumulators, consumes results
    modport master (
        output acc_valid, acc_data, out_ready,
        input  acc_ready, out_valid, out_data, out_idx, out_last
    );

    // Bias stage side
    modport slave (
        input  acc_valid, acc_data, out_ready,
        output acc_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/bias_sat_add.sv
// rtl/bias_sat_add.sv - combinational acc+bias adder, clamping when DENSE_BIAS_SATURATE_EN is defined
module bias_sat_add
    import dense_pkg::*;
(
    input  word_t acc,
    input  word_t bias,
    output word_t sum
);

`ifdef DENSE_BIAS_SATURATE_EN
    localparam word_t WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam word_t WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

    logic [WORD_SIZE:0] wide;

    // One extra sign bit exposes overflow: top two bits disagree -> clamp toward the true sign
    always_comb begin
        wide = {acc[WORD_SIZE-1], acc} + {bias[WORD_SIZE-1], bias};
        if (wide[WORD_SIZE] != wide[WORD_SIZE-1]) begin
            sum = wide[WORD_SIZE] ? WORD_MIN : WORD_MAX;
        end else begin
            sum = wide[WORD_SIZE-1:0];
        end
    end
`else
    // The low word of the widened sum equals the plain word-width sum, so wrap needs no extra bit
    assign sum = acc + bias;
`endif

endmodule

// File: rtl/dense_bias_adder.sv
// rtl/dense_bias_adder.sv - adds per-neuron LUT bias to each MAC accumulator; DENSE_BIAS_SATURATE_EN selects clamping
module dense_bias_adder
    import dense_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    dense_bias_adder_if.slave  bus,
    output idx_t               lut_adr,
    input  word_t              lut_data,
    output logic               done
);

    state_t state_q, state_d;
    idx_t   idx_q, idx_d;
    logic   out_valid_q, out_valid_d;
    word_t  out_data_q, out_data_d;
    idx_t   out_idx_q, out_idx_d;
    logic   out_last_q, out_last_d;
    logic   done_q, done_d;

    word_t  sum;
    logic   acc_ready;
    logic   acc_fire;
    logic   out_fire;

    // The LUT is combinational, so the bias for idx arrives in the same cycle as its accumulator
    bias_sat_add u_add (
        .acc  (bus.acc_data),
        .bias (lut_data),
        .sum  (sum)
    );

    // A new word may enter only when the output register is empty or being drained this cycle
    assign acc_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign acc_fire  = bus.acc_valid && acc_ready;
    assign out_fire  = out_valid_q && bus.out_ready;

    // Pass sequencing: start opens a pass, last accept drains, final fire raises done next cycle
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (acc_fire && idx_q == LAST_IDX) state_d = DRAIN;
            DRAIN: begin
                if (out_fire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: load on accept (wins over a same-cycle fire), otherwise hold until consumed
    always_comb begin
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (acc_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_idx_d   = idx_q;
            out_last_d  = (idx_q == LAST_IDX);
            idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + idx_t'(1);
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset aborts any pass in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign bus.acc_ready = acc_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign lut_adr       = idx_q;
    assign done          = done_q;

endmodule

// File: tb/tb_dense_bias_adder.sv
// tb/tb_dense_bias_adder.sv - scoreboard bench for dense_bias_adder with random stimulus and a reference LUT
module tb_dense_bias_adder;
    import dense_pkg::*;

    typedef struct {
        word_t data;
        idx_t  idx;
        logic  last;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  start = 1'b0;
    idx_t  lut_adr;
    word_t lut_data;
    logic  done;

    dense_bias_adder_if bus ();

    dense_bias_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .lut_adr  (lut_adr),
        .lut_data (lut_data),
        .done     (done)
    );

    word_t lut_rom [NUM_NEURONS] = '{
        32'h012598B0, 32'h0B1A26D0, 32'hFFFE1234, 32'h00421000, 32'h8F000000,
        32'h00000001, 32'h7F000000, 32'hFFFFFFFF, 32'h00ABCDEF, 32'hFFA37200
    };

    assign lut_data = (int'(lut_adr) < NUM_NEURONS) ? lut_rom[lut_adr] : '0;

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_fire_cyc = -10;
    exp_t exp_q[$];
    bit   rand_rdy = 1'b0;
    bit   rand_gaps = 1'b0;
    bit   stall_req = 1'b0;
    bit   stall_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: exact signed sum, clamped or wrapped to a 32-bit word
    function automatic word_t model(input word_t a, input word_t b);
        longint s;
        s = longint'(a) + longint'(b);
`ifdef DENSE_BIAS_SATURATE_EN
        if (s > 64'sd2147483647) return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
`endif
        return word_t'(s[31:0]);
    endfunction

    function automatic word_t acc_val(input int kind, input int i);
        int r;
        if (kind == 0) return '0;
        if (kind == 1) begin
            if (i == 0) return 32'h00010000;
            if (i == 1) return 32'h7FFFFFFF;
            if (i == 9) return 32'h005C8E00;
            return word_t'($urandom);
        end
        r = $urandom_range(0, 3);
        if (r == 0) return 32'h7FFFFFFF;
        if (r == 1) return 32'h80000000;
        return word_t'($urandom);
    endfunction

    // Monitor: every fired result must match the head of the expected queue
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=%h idx=%0d required=none", bus.out_data, bus.out_idx);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e.data || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                    errors++;
                    $display("FAIL result actual=%h/%0d/%b required=%h/%0d/%b",
                             bus.out_data, bus.out_idx, bus.out_last, e.data, e.idx, e.last);
                end
                if (e.last) last_fire_cyc = cyc;
            end
        end
        if (rst_n && done) begin
            done_cnt++;
            checks++;
            if (cyc != last_fire_cyc + 1) begin
                errors++;
                $display("FAIL done_timing actual=%0d required=%0d", cyc, last_fire_cyc + 1);
            end
        end
    end

    // Downstream backpressure, plus a one-off 5-cycle stall while idx3 is presented
    initial begin
        word_t cap;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_req && !stall_done && bus.out_valid && bus.out_idx == idx_t'(3)) begin
                bus.out_ready = 1'b0;
                cap = bus.out_data;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_acc_ready", 32'(bus.acc_ready), 32'd0);
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_data", bus.out_data, cap);
                    chk("stall_idx", 32'(bus.out_idx), 32'd3);
                    chk("stall_lut_adr", 32'(lut_adr), 32'd4);
                    @(posedge clk); #1;
                end
                stall_done = 1'b1;
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input int kind, input int nwords, input bit inject, input bit chain);
        word_t a;
        bit    got;
        int    budget;
        exp_t  e;
        for (int i = 0; i < nwords; i++) begin
            a = acc_val(kind, i);
            if (rand_gaps) begin
                bus.acc_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
            bus.acc_valid = 1'b1;
            bus.acc_data  = a;
            got = 1'b0;
            budget = 0;
            while (!got && budget < 200) begin
                @(negedge clk);
                got = bus.acc_ready;
                @(posedge clk); #1;
                start = 1'b0;
                budget++;
            end
            if (!got) begin
                chk("accept_timeout", 32'd0, 32'd1);
            end else begin
                e.data = model(a, lut_rom[i]);
                e.idx  = idx_t'(i);
                e.last = (i == NUM_NEURONS - 1);
                exp_q.push_back(e);
            end
            if (inject && i == 4) start = 1'b1;
        end
        bus.acc_valid = 1'b0;
        if (nwords < NUM_NEURONS) return;
        if (inject) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        budget = 0;
        while (!done && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("idle_acc_ready", 32'(bus.acc_ready), 32'd0);
        chk("idle_lut_adr", 32'(lut_adr), 32'd0);
        if (chain) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int b;
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc_ready", 32'(bus.acc_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lut_adr", 32'(lut_adr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero accumulators expose the LUT contents in order
        pulse_start();
        run_pass(0, NUM_NEURONS, 1'b0, 1'b0);

        // Directed boundary words: offset, exact cancellation to zero, overflow at idx1
        pulse_start();
        run_pass(1, NUM_NEURONS, 1'b0, 1'b0);

        // Stall while idx3 is held
        stall_req = 1'b1;
        pulse_start();
        run_pass(2, NUM_NEURONS, 1'b0, 1'b0);
        stall_req = 1'b0;
        chk("stall_exercised", 32'(stall_done), 32'd1);

        // Spurious starts in RUN/DRAIN, then back-to-back pass started in the done cycle
        pulse_start();
        run_pass(2, NUM_NEURONS, 1'b1, 1'b1);
        rand_rdy = 1'b1;
        rand_gaps = 1'b1;
        run_pass(2, NUM_NEURONS, 1'b0, 1'b0);

        // Reset after four accepts aborts the pass; the next pass restarts at idx0
        rand_rdy = 1'b0;
        rand_gaps = 1'b0;
        pulse_start();
        run_pass(2, 4, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out_data", bus.out_data, 32'd0);
        chk("abort_out_idx", 32'(bus.out_idx), 32'd0);
        chk("abort_out_last", 32'(bus.out_last), 32'd0);
        chk("abort_acc_ready", 32'(bus.acc_ready), 32'd0);
        chk("abort_lut_adr", 32'(lut_adr), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_rdy = 1'b1;
        rand_gaps = 1'b1;
        pulse_start();
        run_pass(2, NUM_NEURONS, 1'b0, 1'b0);

        b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
